// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - MM:SS BCD stopwatch with pause/adjust and multiplexed seven-segment drive
module stopwatch_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        tick_2hz,
    input  logic        tick_200hz,
    input  logic        tick_blink,
    input  logic        pause_pulse,
    input  logic        adj,
    input  logic        sel,
    output logic        paused,
    output logic [15:0] time_bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blink_phase;
    logic [1:0] digit_idx;

    logic run_inc, adj_sec_inc, adj_min_inc;
    logic sec_wrap, sec_step, min_step;

    logic [3:0] digit_val;
    logic [3:0] an_next;
    logic       blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign time_bcd = {min_tens, min_ones, sec_tens, sec_ones};

    // Ticks are qualified by the pre-toggle paused value, so a coincident
    // pause_pulse never masks or adds an increment on its own edge.
    always_comb begin
        run_inc     = ~paused & ~adj & tick_1hz;
        adj_sec_inc = ~paused &  adj &  sel & tick_2hz;
        adj_min_inc = ~paused &  adj & ~sel & tick_2hz;
        sec_wrap    = (sec_tens == 4'd5) && (sec_ones == 4'd9);
        sec_step    = run_inc | adj_sec_inc;
        min_step    = (run_inc & sec_wrap) | adj_min_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_tens    <= 4'd0;
            min_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            paused      <= 1'b0;
            blink_phase <= 1'b0;
            digit_idx   <= 2'd0;
        end else begin
            if (pause_pulse) paused <= ~paused;
            if (tick_blink) blink_phase <= ~blink_phase;
            if (tick_200hz) digit_idx <= digit_idx + 2'd1;

            if (sec_step) begin
                if (sec_ones == 4'd9) begin
                    sec_ones <= 4'd0;
                    sec_tens <= (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
                end else begin
                    sec_ones <= sec_ones + 4'd1;
                end
            end

            if (min_step) begin
                if (min_ones == 4'd9) begin
                    min_ones <= 4'd0;
                    min_tens <= (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
                end else begin
                    min_ones <= min_ones + 4'd1;
                end
            end
        end
    end

    always_comb begin
        digit_val = sec_ones;
        an_next   = 4'b1110;
        case (digit_idx)
            2'd0: begin digit_val = sec_ones; an_next = 4'b1110; end
            2'd1: begin digit_val = sec_tens; an_next = 4'b1101; end
            2'd2: begin digit_val = min_ones; an_next = 4'b1011; end
            2'd3: begin digit_val = min_tens; an_next = 4'b0111; end
            default: begin digit_val = sec_ones; an_next = 4'b1110; end
        endcase
        // Index 0/1 are the seconds digits, 2/3 the minutes digits.
        blank = adj & blink_phase & (sel ? ~digit_idx[1] : digit_idx[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_next;
            seg <= blank ? 7'b1111111 : decode(digit_val);
        end
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Minutes:seconds stopwatch datapath and four-digit seven-segment driver. It consumes the single-cycle enable pulses from the board clock-divider stage: 1 Hz run, 2 Hz adjust, 200 Hz display scan, and blink toggle. It holds the BCD time, handles pause and adjust modes, and produces the multiplexed, active-low anode/segment drive for the board display.

## Interface
- No parameters; all rates come from the upstream tick pulses.
- clk  in  1  system clock; all ticks are synchronous one-cycle enables in this domain
- rst  in  1  asynchronous, active-high reset
- tick_1hz  in  1  run-mode count enable
- tick_2hz  in  1  adjust-mode count enable
- tick_200hz  in  1  display digit-scan enable
- tick_blink  in  1  blink-phase toggle enable
- pause_pulse  in  1  debounced single-cycle pause request; toggles the paused state
- adj  in  1  1 = adjust mode, 0 = run mode (level)
- sel  in  1  adjust field select: 0 = minutes, 1 = seconds (level)
- paused  out  1  current pause state
- time_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
- an  out  4  digit anodes, active-low one-hot
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- **State:**
  - min_tens and sec_tens hold 0–5; min_ones and sec_ones hold 0–9.
  - paused flag.
  - blink_phase bit.
  - 2-bit digit index.
- **Run mode** (adj=0, paused=0), on tick_1hz:
  - Increment seconds; 59 wraps to 00 and carries +1 into minutes.
  - 59:59 wraps to 00:00.
  - tick_2hz is ignored.
- **Adjust mode** (adj=1, paused=0), on tick_2hz, only the selected field increments:
  - sel=0: minutes +1; 59 wraps to 00; seconds unchanged.
  - sel=1: seconds +1; 59 wraps to 00; no carry into minutes.
  - tick_1hz is ignored.
- **Paused** (paused=1): time is frozen in both modes. Scan and blink continue.
- **pause_pulse:**
  - Toggles paused on the same edge.
  - A tick coincident with pause_pulse is qualified by the pre-toggle paused value.
- **Mode or select changes:** adj and sel changes take effect on the next qualifying tick. No state is cleared.
- **Scan:**
  - Digit index increments mod 4 on tick_200hz.
  - Index 0 → an=1110, sec_ones.
  - Index 1 → an=1101, sec_tens.
  - Index 2 → an=1011, min_ones.
  - Index 3 → an=0111, min_tens.
- **Decode** (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- **Blink:**
  - blink_phase toggles on tick_blink.
  - When adj=1 and blink_phase=1, digits of the selected field output seg=1111111. Their anode is still driven.
  - When adj=0, digits are never blanked.
- **Value range:** BCD values outside the legal ranges are unreachable. The decoder maps any value >9 to blank (1111111).

## Timing
- **Reset values** (all outputs registered):
  - time_bcd=16'h0000, paused=0, blink_phase=0, digit index=0.
  - an=1110, seg=1000000.
- **Time update:** time_bcd updates on the edge at which the qualifying tick is high. The increment takes effect 0 cycles after that edge.
- **Display latency:** an/seg are registered from the digit index, time registers and blink state. Any change appears on an/seg one clock after the causing edge.
- **Tick width:** each tick is honoured once per high cycle. Back-to-back ticks on consecutive cycles each count.
- **Simultaneous ticks:** tick_1hz and tick_2hz on the same cycle act according to adj only. At most one increment occurs per cycle.
- **Reset during operation:** rst asserted mid-count clears everything immediately and asynchronously. On release, counting resumes from 00:00 in the run state.

## Test plan
1. Reset → an=1110, seg=1000000, paused=0, time_bcd=0000. Then 4 tick_200hz → an cycles 1101, 1011, 0111, 1110, each one clock after its tick.
2. Run mode, 60 tick_1hz → time_bcd=0100. At index 2, seg=1111001. Continue to 3599 ticks → 5959. One more tick → 0000.
3. pause_pulse, then 5 tick_1hz → time unchanged, paused=1. Second pause_pulse coincident with tick_1hz → no increment that cycle, paused=0. Next tick → +1 second.
4. Running, pause_pulse coincident with tick_1hz → time +1 and paused=1 on the same edge.
5. adj=1, sel=1 at 0059, one tick_2hz → 0000. With sel=0 at 5930, one tick_2hz → 0030. tick_1hz ignored throughout.
6. adj=1, sel=0, blink_phase=1 → seg=1111111 at index 2/3, digits normal at index 0/1. Set adj=0 → no blanking on any index.
